grf_wb_arbiter: RTL and testbench

//  Single writer for the GRF write port (WE/A3/WD/PC). Merges W-stage pipeline results with

---
 rtl/grf_wb_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_grf_wb_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/grf_wb_arbiter.sv
// grf_wb_arbiter
//   Single writer for the GRF write port. W-stage results always win a write
//   slot. Late results (MDU/CP0) are queued in a small FIFO and drained into
//   cycles where the pipeline does not write. A pending-write mask exported to
//   decode marks every register that still has a live queued result.
//
// Optional feature macro: WB_TRACE_EN (simulation-only trace of every GRF write).
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   pipe_we/a3/wd/pc            W-stage write request (never back-pressured)
//   lt_valid/lt_ready           late-result handshake
//   lt_a3/wd/pc                 late-result payload
//   grf_we/a3/wd/pc             registered GRF write port
//   pending_mask                bit r set while a valid queued entry targets $r
//   fifo_count                  occupied FIFO slots (killed entries included)
module grf_wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pipe_we,
  input  logic [4:0]       pipe_a3,
  input  logic [31:0]      pipe_wd,
  input  logic [31:0]      pipe_pc,
  input  logic             lt_valid,
  output logic             lt_ready,
  input  logic [4:0]       lt_a3,
  input  logic [31:0]      lt_wd,
  input  logic [31:0]      lt_pc,
  output logic             grf_we,
  output logic [4:0]       grf_a3,
  output logic [31:0]      grf_wd,
  output logic [31:0]      grf_pc,
  output logic [31:0]      pending_mask,
  output logic [PTR_W:0]   fifo_count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0] CNT_ONE = (PTR_W+1)'(1);

  logic [4:0]       ent_a3_r [DEPTH];
  logic [31:0]      ent_wd_r [DEPTH];
  logic [31:0]      ent_pc_r [DEPTH];
  logic [DEPTH-1:0] ent_vld_r;
  logic [DEPTH-1:0] ent_vld_s;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W:0]   count_r;
  logic [PTR_W:0]   count_s;

  logic             pipe_slot_s;
  logic             head_vld_s;
  logic             enq_s;
  logic             drain_s;
  logic             pop_s;
  logic [31:0]      mask_s;

  // Handshake, arbitration and pop decisions.
  always_comb begin
    pipe_slot_s = pipe_we && (pipe_a3 != 5'd0);
    head_vld_s  = (count_r != {(PTR_W+1){1'b0}}) && ent_vld_r[rd_ptr_r];
    lt_ready    = (count_r < FULL_CNT);
    // $0 results are handshaken but never stored.
    enq_s       = lt_valid && lt_ready && (lt_a3 != 5'd0);
    drain_s     = !pipe_slot_s && head_vld_s;
    // A killed head is discarded regardless of pipe activity.
    pop_s       = (count_r != {(PTR_W+1){1'b0}}) && (drain_s || !ent_vld_r[rd_ptr_r]);
  end

  // Next valid bits: kill matching entries, clear popped slot, then mark the new
  // entry so an enqueue in a kill cycle survives.
  always_comb begin
    ent_vld_s = ent_vld_r;
    for (int i = 0; i < DEPTH; i++) begin
      if (pipe_slot_s && (ent_a3_r[i] == pipe_a3)) begin
        ent_vld_s[i] = 1'b0;
      end else begin
        ent_vld_s[i] = ent_vld_s[i];
      end
    end
    if (pop_s) begin
      ent_vld_s[rd_ptr_r] = 1'b0;
    end else begin
      ent_vld_s = ent_vld_s;
    end
    if (enq_s) begin
      ent_vld_s[wr_ptr_r] = 1'b1;
    end else begin
      ent_vld_s = ent_vld_s;
    end
  end

  // Next occupancy count.
  always_comb begin
    case ({enq_s, pop_s})
      2'b10:   count_s = count_r + CNT_ONE;
      2'b01:   count_s = count_r - CNT_ONE;
      default: count_s = count_r;
    endcase
  end

  // Pending-write mask from live entries; $0 never reported.
  always_comb begin
    mask_s = 32'h0000_0000;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld_r[i]) begin
        mask_s[ent_a3_r[i]] = 1'b1;
      end else begin
        mask_s = mask_s;
      end
    end
    mask_s[0] = 1'b0;
  end

  assign pending_mask = mask_s;
  assign fifo_count   = count_r;

  // FIFO pointers, count and valid bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_r  <= {PTR_W{1'b0}};
      wr_ptr_r  <= {PTR_W{1'b0}};
      count_r   <= {(PTR_W+1){1'b0}};
      ent_vld_r <= {DEPTH{1'b0}};
    end else begin
      ent_vld_r <= ent_vld_s;
      count_r   <= count_s;
      if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
      if (enq_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
    end
  end

  // FIFO payload storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_a3_r[i] <= 5'd0;
        ent_wd_r[i] <= 32'h0000_0000;
        ent_pc_r[i] <= 32'h0000_0000;
      end
    end else if (enq_s) begin
      ent_a3_r[wr_ptr_r] <= lt_a3;
      ent_wd_r[wr_ptr_r] <= lt_wd;
      ent_pc_r[wr_ptr_r] <= lt_pc;
    end
  end

  // Registered GRF write port; address/data hold when nothing is written.
  always_ff @(posedge clk) begin
    if (reset) begin
      grf_we <= 1'b0;
      grf_a3 <= 5'd0;
      grf_wd <= 32'h0000_0000;
      grf_pc <= 32'h0000_0000;
    end else if (pipe_slot_s) begin
      grf_we <= 1'b1;
      grf_a3 <= pipe_a3;
      grf_wd <= pipe_wd;
      grf_pc <= pipe_pc;
    end else if (drain_s) begin
      grf_we <= 1'b1;
      grf_a3 <= ent_a3_r[rd_ptr_r];
      grf_wd <= ent_wd_r[rd_ptr_r];
      grf_pc <= ent_pc_r[rd_ptr_r];
    end else begin
      grf_we <= 1'b0;
    end
  end

`ifdef WB_TRACE_EN
  // Simulation trace: one line per GRF write.
  always_ff @(posedge clk) begin
    if (grf_we) $display("%d@%h: $%d <= %h", $time, grf_pc, grf_a3, grf_wd);
  end
`else
`endif

endmodule

// File: tb/tb_grf_wb_arbiter.sv
module tb_grf_wb_arbiter;

  logic        clk;
  logic        reset;
  logic        pipe_we;
  logic [4:0]  pipe_a3;
  logic [31:0] pipe_wd;
  logic [31:0] pipe_pc;
  logic        lt_valid;
  logic        lt_ready;
  logic [4:0]  lt_a3;
  logic [31:0] lt_wd;
  logic [31:0] lt_pc;
  logic        grf_we;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd;
  logic [31:0] grf_pc;
  logic [31:0] pending_mask;
  logic [2:0]  fifo_count;

  int n_checks;
  int n_errors;

  grf_wb_arbiter #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .reset(reset),
    .pipe_we(pipe_we), .pipe_a3(pipe_a3), .pipe_wd(pipe_wd), .pipe_pc(pipe_pc),
    .lt_valid(lt_valid), .lt_ready(lt_ready), .lt_a3(lt_a3), .lt_wd(lt_wd), .lt_pc(lt_pc),
    .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc),
    .pending_mask(pending_mask), .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pipe(input logic we, input logic [4:0] a3, input logic [31:0] wd,
                          input logic [31:0] pc);
    pipe_we = we; pipe_a3 = a3; pipe_wd = wd; pipe_pc = pc;
  endtask

  task automatic set_lt(input logic v, input logic [4:0] a3, input logic [31:0] wd,
                        input logic [31:0] pc);
    lt_valid = v; lt_a3 = a3; lt_wd = wd; lt_pc = pc;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    set_pipe(1'b0, 5'd0, 32'h0, 32'h0);
    set_lt(1'b0, 5'd0, 32'h0, 32'h0);
    tick(); tick();
    reset = 1'b0;

    // 1: reset state, single pipe write, idle hold
    check("rst_we", {31'd0, grf_we}, 32'd0);
    check("rst_a3", {27'd0, grf_a3}, 32'd0);
    check("rst_wd", grf_wd, 32'd0);
    check("rst_pc", grf_pc, 32'd0);
    check("rst_mask", pending_mask, 32'd0);
    check("rst_count", {29'd0, fifo_count}, 32'd0);
    check("rst_ready", {31'd0, lt_ready}, 32'd1);
    set_pipe(1'b1, 5'd5, 32'h1234, 32'h100);
    tick();
    check("t1_we", {31'd0, grf_we}, 32'd1);
    check("t1_a3", {27'd0, grf_a3}, 32'd5);
    check("t1_wd", grf_wd, 32'h1234);
    check("t1_pc", grf_pc, 32'h100);
    set_pipe(1'b0, 5'd0, 32'h0, 32'h0);
    tick();
    check("t1_idle_we", {31'd0, grf_we}, 32'd0);
    check("t1_idle_a3", {27'd0, grf_a3}, 32'd5);

    // 2: late result waits behind pipe slots
    set_pipe(1'b1, 5'd3, 32'h1, 32'h104);
    set_lt(1'b1, 5'd7, 32'hAA, 32'h200);
    tick();
    set_lt(1'b0, 5'd0, 32'h0, 32'h0);
    check("t2_count", {29'd0, fifo_count}, 32'd1);
    check("t2_mask", pending_mask, 32'h80);
    check("t2_pipe_a3", {27'd0, grf_a3}, 32'd3);
    tick();
    check("t2_hold_a3", {27'd0, grf_a3}, 32'd3);
    check("t2_hold_mask", pending_mask, 32'h80);
    set_pipe(1'b0, 5'd0, 32'h0, 32'h0);
    tick();
    check("t2_we", {31'd0, grf_we}, 32'd1);
    check("t2_a3", {27'd0, grf_a3}, 32'd7);
    check("t2_wd", grf_wd, 32'hAA);
    check("t2_pc", grf_pc, 32'h200);
    check("t2_mask0", pending_mask, 32'd0);
    check("t2_count0", {29'd0, fifo_count}, 32'd0);

    // 3: fill FIFO, back-pressure, wrap, drain in order
    set_pipe(1'b1, 5'd3, 32'h2, 32'h108);
    for (int i = 0; i < 4; i++) begin
      set_lt(1'b1, 5'(10 + i), 32'hB0 + 32'(i), 32'h300 + 32'(4 * i));
      tick();
    end
    check("t3_full_count", {29'd0, fifo_count}, 32'd4);
    check("t3_full_ready", {31'd0, lt_ready}, 32'd0);
    check("t3_full_mask", pending_mask, 32'h3C00);
    set_lt(1'b1, 5'd14, 32'hB4, 32'h310);
    tick();
    check("t3_stall_count", {29'd0, fifo_count}, 32'd4);
    check("t3_stall_ready", {31'd0, lt_ready}, 32'd0);
    set_pipe(1'b0, 5'd0, 32'h0, 32'h0);
    tick();
    check("t3_d0_a3", {27'd0, grf_a3}, 32'd10);
    check("t3_d0_wd", grf_wd, 32'hB0);
    check("t3_d0_count", {29'd0, fifo_count}, 32'd3);
    check("t3_d0_ready", {31'd0, lt_ready}, 32'd1);
    tick();
    set_lt(1'b0, 5'd0, 32'h0, 32'h0);
    check("t3_d1_a3", {27'd0, grf_a3}, 32'd11);
    check("t3_d1_count", {29'd0, fifo_count}, 32'd3);
    check("t3_d1_mask", pending_mask, 32'h7000);
    for (int i = 2; i < 5; i++) begin
      tick();
      check("t3_dn_we", {31'd0, grf_we}, 32'd1);
      check("t3_dn_a3", {27'd0, grf_a3}, 32'(10 + i));
      check("t3_dn_wd", grf_wd, 32'hB0 + 32'(i));
    end
    check("t3_last_pc", grf_pc, 32'h310);
    check("t3_end_count", {29'd0, fifo_count}, 32'd0);

    // 4: younger pipe write kills buffered entry
    set_pipe(1'b1, 5'd3, 32'h3, 32'h10C);
    set_lt(1'b1, 5'd9, 32'h99, 32'h380);
    tick();
    set_lt(1'b0, 5'd0, 32'h0, 32'h0);
    check("t4_count", {29'd0, fifo_count}, 32'd1);
    check("t4_mask", pending_mask, 32'h200);
    set_pipe(1'b1, 5'd9, 32'h55, 32'h400);
    tick();
    check("t4_we", {31'd0, grf_we}, 32'd1);
    check("t4_a3", {27'd0, grf_a3}, 32'd9);
    check("t4_wd", grf_wd, 32'h55);
    check("t4_kill_mask", pending_mask, 32'd0);
    check("t4_kill_count", {29'd0, fifo_count}, 32'd1);
    set_pipe(1'b0, 5'd0, 32'h0, 32'h0);
    tick();
    check("t4_pop_we", {31'd0, grf_we}, 32'd0);
    check("t4_pop_count", {29'd0, fifo_count}, 32'd0);
    check("t4_pop_wd", grf_wd, 32'h55);

    // 5: $0 destinations
    set_pipe(1'b1, 5'd0, 32'hDEAD, 32'h404);
    set_lt(1'b1, 5'd0, 32'hBEEF, 32'h408);
    #1;
    check("t5_ready", {31'd0, lt_ready}, 32'd1);
    tick();
    set_pipe(1'b0, 5'd0, 32'h0, 32'h0);
    set_lt(1'b0, 5'd0, 32'h0, 32'h0);
    check("t5_we", {31'd0, grf_we}, 32'd0);
    check("t5_count", {29'd0, fifo_count}, 32'd0);
    check("t5_mask", pending_mask, 32'd0);
    tick();
    check("t5_we2", {31'd0, grf_we}, 32'd0);

    // 6: reset discards buffered entries
    set_pipe(1'b1, 5'd3, 32'h4, 32'h410);
    for (int i = 0; i < 3; i++) begin
      set_lt(1'b1, 5'(20 + i), 32'hC0 + 32'(i), 32'h500);
      tick();
    end
    set_lt(1'b0, 5'd0, 32'h0, 32'h0);
    check("t6_count", {29'd0, fifo_count}, 32'd3);
    check("t6_mask", pending_mask, 32'h0070_0000);
    set_pipe(1'b0, 5'd0, 32'h0, 32'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_rst_count", {29'd0, fifo_count}, 32'd0);
    check("t6_rst_mask", pending_mask, 32'd0);
    check("t6_rst_we", {31'd0, grf_we}, 32'd0);
    check("t6_rst_ready", {31'd0, lt_ready}, 32'd1);
    tick();
    check("t6_after_we", {31'd0, grf_we}, 32'd0);
    check("t6_after_count", {29'd0, fifo_count}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
